// File: rtl/serial_word_compare_pkg.sv
// Shared definitions for the serial word comparator: one-hot result codes
// and the FSM state encoding.
// Imported by nibble_cmp4 and serial_word_compare.
package serial_word_compare_pkg;

  // Result codes shared with the upstream 4-bit compare stage.
  // CMP_NONE is only ever seen out of reset.
  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_LT   = 3'b010;
  localparam logic [2:0] CMP_EQ   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : serial_word_compare_pkg

// File: rtl/serial_word_compare_nibble_cmp4.sv
// nibble_cmp4: unsigned 4-bit magnitude compare with a cascade input.
// Latency: combinational. Backpressure: none, it is a pure function.
// Ports: a, b = nibbles to compare; cascade = code used when a == b;
//        result = CMP_GT / CMP_LT, otherwise the cascade code verbatim.
module nibble_cmp4
  import serial_word_compare_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] cascade,
  output logic [2:0] result
);

  always_comb begin
    result = cascade;
    if (a > b) begin
      result = CMP_GT;
    end else if (a < b) begin
      result = CMP_LT;
    end
  end

endmodule : nibble_cmp4

// File: rtl/serial_word_compare.sv
// serial_word_compare: MSB-first nibble-serial magnitude compare of two WIDTH-bit words, early exit on first unequal nibble.
// Latency: oDone rises j+1 edges after the start edge (j = first differing nibble, MSB = 0), NIB edges if equal.
// Backpressure: none; iStart is ignored while oBusy=1, and a new start may be accepted in the oDone cycle.
// Ports: iClk/iRst_n clock and async active-low reset; iStart request pulse;
//        iData_a/iData_b operands and iCascade (less-significant result), captured on the accepted start;
//        oBusy comparison in progress; oDone one-cycle result strobe; oResult one-hot code, held until next done.
module serial_word_compare
  import serial_word_compare_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iCascade,
  output logic             oBusy,
  output logic             oDone,
  output logic [2:0]       oResult
);

  localparam int NIB = WIDTH / 4;
  // A single-nibble word still needs a 1-bit counter to keep the logic legal.
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [2:0]       casc;
  logic [CW-1:0]    cnt;
  logic [2:0]       nib_res;

  // Cascade tied to CMP_EQ so that nib_res == CMP_EQ means "this nibble is equal";
  // the captured cascade is only applied once every nibble has matched.
  nibble_cmp4 u_nibble_cmp4 (
    .a       (sh_a[WIDTH-1 -: 4]),
    .b       (sh_b[WIDTH-1 -: 4]),
    .cascade (CMP_EQ),
    .result  (nib_res)
  );

  // The busy flag is the state register itself, so it is glitch-free.
  assign oBusy = (state == RUN);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      casc    <= CMP_NONE;
      cnt     <= '0;
      oDone   <= 1'b0;
      oResult <= CMP_NONE;
    end else begin
      oDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iStart) begin
            sh_a  <= iData_a;
            sh_b  <= iData_b;
            casc  <= iCascade;
            cnt   <= CW'(NIB - 1);
            state <= RUN;
          end
        end
        RUN: begin
          if (nib_res != CMP_EQ) begin
            oResult <= nib_res;
            oDone   <= 1'b1;
            state   <= IDLE;
          end else if (cnt == '0) begin
            oResult <= casc;
            oDone   <= 1'b1;
            state   <= IDLE;
          end else begin
            // Zero fill keeps the shifted-out tail equal, which never matters
            // because cnt reaches 0 before the fill reaches the top nibble.
            sh_a <= sh_a << 4;
            sh_b <= sh_b << 4;
            cnt  <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : serial_word_compare

// File: doc/serial_word_compare.md
Name: serial_word_compare

Overview:
- Sequential magnitude comparator for wide words. It compares two WIDTH-bit operands one 4-bit nibble per clock, starting at the most significant nibble.
- It consumes the 3-bit cascade result code of the 4-bit comparator stage and folds it across nibbles.
- It exits early on the first unequal nibble.
- It sits directly downstream of the 4-bit compare stage. Its own result uses the same one-hot code, so instances can be chained through iCascade.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4
NIB, WIDTH/4, derived nibble count; not overridable

Ports:
iClk  input  1  clock, all state updates on rising edge
iRst_n  input  1  asynchronous active-low reset
iStart  input  1  request pulse; sampled only when oBusy=0
iData_a  input  WIDTH  operand A, captured on the accepted-start edge
iData_b  input  WIDTH  operand B, captured on the accepted-start edge
iCascade  input  3  result from less-significant stage, captured with operands; 3'b001 when unchained
oBusy  output  1  high while a comparison is in progress
oDone  output  1  one-cycle pulse, result valid
oResult  output  3  3'b100 A>B, 3'b010 A<B, otherwise captured iCascade value; held until next done

Behaviour:
- Clock and reset: one clock, iClk. Reset iRst_n is asynchronous and active-low.
- Reset values: state=IDLE, oBusy=0, oDone=0, oResult=3'b000, and both shift registers and the nibble counter cleared.
- Reset asserted mid-operation aborts immediately. No oDone is produced for the aborted request.
- States:
  - IDLE: oBusy=0. On an edge with iStart=1:
    - load shA<=iData_a, shB<=iData_b, casc<=iCascade, cnt<=NIB-1;
    - go to RUN.
  - RUN: oBusy=1. Each edge compares shA[WIDTH-1:WIDTH-4] with shB[WIDTH-1:WIDTH-4], unsigned:
    - A nibble greater: oResult<=3'b100, oDone<=1, go to IDLE.
    - A nibble less: oResult<=3'b010, oDone<=1, go to IDLE.
    - Equal and cnt==0: oResult<=casc, oDone<=1, go to IDLE.
    - Equal and cnt!=0: shift both registers left 4 bits (zero fill), cnt<=cnt-1, stay in RUN.
- oDone: registered; high exactly one cycle, the cycle after the decision edge. Low on every other cycle.
- oResult: updates only on a decision edge.
- Latency: if the first differing nibble is index j (0 = most significant), oDone rises j+1 edges after the start edge. For equal operands it rises NIB edges after the start edge.
- Throughput: a new start may be accepted in the same cycle oDone is high, since the block is already back in IDLE.
- iStart while oBusy=1 is ignored, with no queuing. Operand inputs are don't-care after capture.
- iCascade is passed through unchecked. A non-one-hot value appears verbatim on oResult when the operands are equal.
- cnt width is clog2(NIB), with a minimum of 1 bit.
- For WIDTH=4, the single RUN cycle always decides.

Decomposition:
- Shared package holds:
  - result-code constants CMP_GT=3'b100, CMP_LT=3'b010, CMP_EQ=3'b001, CMP_NONE=3'b000;
  - state encoding IDLE/RUN.
- One natural sub-module: nibble_cmp4, a combinational 4-bit compare with cascade input. It is instantiated on the top nibbles with cascade tied to CMP_EQ; the FSM consumes its 3-bit code.

Test Plan:
- WIDTH=16, A=16'h1234, B=16'h1234, iCascade=3'b001, start pulse → oDone 4 edges later, oResult=3'b001, oBusy high for 4 cycles.
- A=16'h9000, B=16'h1FFF → oDone 1 edge after start, oResult=3'b100.
- A=16'h12A4, B=16'h12B4 → oDone 3 edges after start, oResult=3'b010. oResult stays 3'b010 through the following idle cycles.
- A=B=16'hFFFF, iCascade=3'b100 → oResult=3'b100 after 4 edges (chaining). Repeat with iCascade=3'b010 → 3'b010.
- Start A=16'h0001, B=16'h0002; pulse iStart again at edge 2 with different operands → ignored, result 3'b010 at edge 4. Then assert iRst_n=0 mid-run of a new request → oBusy=0, oDone=0, oResult=3'b000 immediately, and no done after release.
- Back-to-back: iStart held high in the oDone cycle with A=16'h0000, B=16'h0001 → accepted, second oDone 4 edges later with 3'b010.
